// File: rtl/dc_blanking_multi.sv
// DC-bin blanker: replaces samples at up to NUM_POS programmable frame indices with zero or the last clean sample.
// Optional saturating blanked-sample counter on blank_cnt when DC_BLANK_STATS_EN is defined.

module dc_blank_pos_cmp #(
  parameter int FRAME_W = 10
) (
  input  logic [FRAME_W-1:0] idx,
  input  logic [FRAME_W-1:0] flen,
  input  logic [FRAME_W-1:0] pos_idx,
  input  logic               pos_vld,
  output logic               hit
);
  // A position at or beyond the frame length can never be reached, so it never matches.
  assign hit = pos_vld && (idx == pos_idx) && ((flen == '0) || (pos_idx < flen));
endmodule

module dc_blanking_multi #(
  parameter int DATA_W    = 32,
  parameter int FRAME_W   = 10,
  parameter int NUM_POS   = 4,
  parameter int BASE_ADDR = 4
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              set_stb,
  input  logic [7:0]        set_addr,
  input  logic [31:0]       set_data,
  input  logic              dv_in,
  input  logic              sof_in,
  input  logic [DATA_W-1:0] data_in,
  output logic              dv_out,
  output logic [DATA_W-1:0] data_out,
  output logic              blanked_out,
  output logic [31:0]       blank_cnt
);
  typedef enum logic [1:0] {IDLE, ARMED, RUN} state_t;

  localparam logic [7:0] A_CTRL = 8'(BASE_ADDR);
  localparam logic [7:0] A_FLEN = 8'(BASE_ADDR + 1);

  state_t                           state;
  logic                             ctrl_en, ctrl_mode, ctrl_sync, ctrl_wr;
  logic [FRAME_W-1:0]               flen;
  logic [NUM_POS-1:0]               pos_vld;
  logic [NUM_POS-1:0][FRAME_W-1:0]  pos_idx;
  logic [FRAME_W-1:0]               cnt, cur_idx, cnt_nxt;
  logic [FRAME_W:0]                 inc;
  logic                             wr_ctrl, wr_flen, elig;

  logic [2:1]                       vld_pipe;
  logic [DATA_W-1:0]                s1_data, hold;
  logic [FRAME_W-1:0]               s1_idx;
  logic                             s1_elig, blank;
  logic [NUM_POS-1:0]               hits;
  logic                             unused_bits;

  assign unused_bits = ^set_data;
  assign wr_ctrl     = set_stb && (set_addr == A_CTRL);
  assign wr_flen     = set_stb && (set_addr == A_FLEN);

  // sof restarts the frame at index 0 for the sample that carries it
  assign cur_idx = (dv_in && sof_in) ? '0 : cnt;
  assign inc     = {1'b0, cur_idx} + 1'b1;
  assign cnt_nxt = (inc[FRAME_W] || ((flen != '0) && (inc[FRAME_W-1:0] >= flen))) ? '0
                                                                                 : inc[FRAME_W-1:0];
  assign elig    = (state == RUN) || ((state == ARMED) && ctrl_en && dv_in && sof_in);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      ctrl_en   <= 1'b0;
      ctrl_mode <= 1'b0;
      ctrl_sync <= 1'b0;
      ctrl_wr   <= 1'b0;
      flen      <= '0;
      pos_vld   <= '0;
      pos_idx   <= '0;
    end else begin
      ctrl_wr <= wr_ctrl;
      if (wr_ctrl) {ctrl_sync, ctrl_mode, ctrl_en} <= set_data[2:0];
      if (wr_flen) flen <= set_data[FRAME_W-1:0];
      for (int k = 0; k < NUM_POS; k++) begin
        if (set_stb && (set_addr == 8'(BASE_ADDR + 2 + k))) begin
          pos_vld[k] <= set_data[31];
          pos_idx[k] <= set_data[FRAME_W-1:0];
        end
      end
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      case (state)
        IDLE: begin
          cnt <= '0;
          if (ctrl_en) state <= ctrl_sync ? ARMED : RUN;
        end
        ARMED: begin
          if (!ctrl_en) state <= IDLE;
          else if (dv_in && sof_in) begin
            state <= RUN;
            cnt   <= cnt_nxt;
          end
        end
        RUN: begin
          if (!ctrl_en) state <= IDLE;
          else if (ctrl_wr && ctrl_sync) state <= ARMED;
          if (dv_in) cnt <= cnt_nxt;
        end
        default: state <= IDLE;
      endcase
      if (wr_flen) cnt <= '0;
    end
  end

  for (genvar k = 0; k < NUM_POS; k++) begin : g_pos
    dc_blank_pos_cmp #(.FRAME_W(FRAME_W)) u_cmp (
      .idx     (s1_idx),
      .flen    (flen),
      .pos_idx (pos_idx[k]),
      .pos_vld (pos_vld[k]),
      .hit     (hits[k])
    );
  end

  assign blank = vld_pipe[1] && s1_elig && (|hits);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      vld_pipe    <= '0;
      s1_data     <= '0;
      s1_idx      <= '0;
      s1_elig     <= 1'b0;
      hold        <= '0;
      data_out    <= '0;
      blanked_out <= 1'b0;
    end else begin
      vld_pipe    <= {vld_pipe[1], dv_in};
      s1_data     <= data_in;
      s1_idx      <= cur_idx;
      s1_elig     <= elig;
      blanked_out <= blank;
      data_out    <= blank ? (ctrl_mode ? hold : '0) : s1_data;
      if (vld_pipe[1] && !blank) hold <= s1_data;
    end
  end

  assign dv_out = vld_pipe[2];

`ifdef DC_BLANK_STATS_EN
  always_ff @(posedge clock or negedge reset) begin
    if (!reset)                                         blank_cnt <= '0;
    else if (wr_ctrl)                                   blank_cnt <= '0;
    else if (dv_out && blanked_out && (blank_cnt != '1)) blank_cnt <= blank_cnt + 1'b1;
  end
`else
  assign blank_cnt = '0;
`endif

endmodule

// File: tb/tb_dc_blanking_multi.sv
// Scoreboard bench for dc_blanking_multi: expected samples queued at drive time, compared at dv_out.
module tb_dc_blanking_multi;
  logic        clock = 1'b0;
  logic        rst_n = 1'b0;
  logic        set_stb = 1'b0;
  logic [7:0]  set_addr = '0;
  logic [31:0] set_data = '0;
  logic        dv_in = 1'b0, sof_in = 1'b0;
  logic [31:0] data_in = '0;
  logic        dv_out, blanked_out;
  logic [31:0] data_out, blank_cnt;

  typedef struct {logic [31:0] d; logic b; int c;} exp_t;
  exp_t sb[$];
  int   cyc = 0;
  int   n_cmp = 0, n_err = 0;

  localparam int BASE = 4;
  localparam logic [31:0] V = 32'h8000_0000;

  dc_blanking_multi #(.DATA_W(32), .FRAME_W(10), .NUM_POS(4), .BASE_ADDR(BASE)) dut (
    .clock(clock), .reset(rst_n), .set_stb(set_stb), .set_addr(set_addr), .set_data(set_data),
    .dv_in(dv_in), .sof_in(sof_in), .data_in(data_in), .dv_out(dv_out), .data_out(data_out),
    .blanked_out(blanked_out), .blank_cnt(blank_cnt)
  );

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  always @(negedge clock) begin
    if (rst_n && dv_out) begin
      if (sb.size() == 0) chk("unexpected_dv", 1, 0);
      else begin
        exp_t e;
        e = sb.pop_front();
        chk("data", data_out, e.d);
        chk("blanked", blanked_out, e.b);
        chk("latency", cyc, e.c);
      end
    end
  end

  task automatic send(input logic [31:0] d, input logic sof, input logic [31:0] ed, input logic eb);
    @(posedge clock); #1;
    dv_in = 1'b1; sof_in = sof; data_in = d;
    sb.push_back('{ed, eb, cyc + 2});
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clock); #1;
      dv_in = 1'b0; sof_in = 1'b0;
    end
  endtask

  task automatic wr(input int a, input logic [31:0] d);
    @(posedge clock); #1;
    dv_in = 1'b0; sof_in = 1'b0;
    set_stb = 1'b1; set_addr = 8'(a); set_data = d;
    @(posedge clock); #1;
    set_stb = 1'b0;
  endtask

  task automatic chk_cnt(input string tag, input logic [31:0] when_on);
    @(negedge clock);
`ifdef DC_BLANK_STATS_EN
    chk(tag, blank_cnt, when_on);
`else
    chk(tag, blank_cnt, when_on & 32'h0);
`endif
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic b;
    // reset state
    repeat (3) begin
      @(negedge clock);
      chk("rst_dv", dv_out, 0);
      chk("rst_data", data_out, 0);
      chk("rst_blank", blanked_out, 0);
      chk("rst_cnt", blank_cnt, 0);
    end
    @(posedge clock); #1 rst_n = 1'b1;

    // disabled pass-through with 2-cycle latency
    for (int i = 1; i <= 10; i++) send(i, 1'b0, i, 1'b0);
    idle(4);

    // zero-mode blanking across a wrap of L=8
    wr(BASE + 1, 8);
    wr(BASE + 2, V | 0);
    wr(BASE + 3, V | 5);
    wr(BASE + 0, 32'h1);
    idle(2);
    for (int s = 1; s <= 20; s++) begin
      b = (((s - 1) % 8) == 0) || (((s - 1) % 8) == 5);
      send(s, 1'b0, b ? 32'h0 : 32'(s), b);
    end
    idle(4);
    chk_cnt("stats_after_zero", 5);
    wr(BASE + 0, 32'h0);
    idle(1);
    chk_cnt("stats_cleared", 0);

    // hold mode with gapped valid
    wr(BASE + 1, 4);
    wr(BASE + 2, V | 2);
    wr(BASE + 3, 0);
    wr(BASE + 0, 32'h3);
    idle(2);
    send(32'hA, 1'b0, 32'hA, 1'b0); idle(1);
    send(32'hB, 1'b0, 32'hB, 1'b0); idle(1);
    send(32'hC, 1'b0, 32'hB, 1'b1); idle(1);
    send(32'hD, 1'b0, 32'hD, 1'b0);
    idle(4);
    wr(BASE + 0, 32'h0);
    idle(2);

    // sync arm: only the sof sample starts the frame; sof without dv is ignored
    wr(BASE + 1, 16);
    wr(BASE + 2, V | 0);
    wr(BASE + 0, 32'h5);
    idle(2);
    for (int i = 0; i < 5; i++) send(32'h11 + i, 1'b0, 32'h11 + i, 1'b0);
    @(posedge clock); #1 dv_in = 1'b0; sof_in = 1'b1;
    send(32'h55, 1'b1, 32'h0, 1'b1);
    for (int i = 0; i < 3; i++) send(32'h56 + i, 1'b0, 32'h56 + i, 1'b0);

    // reconfiguration mid-frame: FLEN write restarts the index
    wr(BASE + 2, V | 1);
    send(32'h60, 1'b0, 32'h60, 1'b0);
    send(32'h61, 1'b0, 32'h61, 1'b0);
    wr(BASE + 1, 4);
    wr(BASE + 3, V | 9);
    for (int k = 0; k < 10; k++) begin
      b = (k % 4) == 1;
      send(32'h70 + k, 1'b0, b ? 32'h0 : 32'h70 + k, b);
    end
    idle(4);
    chk_cnt("stats_after_reconf", 4);

    // reset mid-frame drops everything in flight
    send(32'h77, 1'b0, 32'h77, 1'b0);
    @(posedge clock); #1;
    dv_in = 1'b0; rst_n = 1'b0;
    sb.delete();
    #1;
    chk("midrst_dv", dv_out, 0);
    chk("midrst_data", data_out, 0);
    chk("midrst_cnt", blank_cnt, 0);
    @(posedge clock); #1 rst_n = 1'b1;
    idle(4);

    for (int i = 0; i < 20 && sb.size() != 0; i++) @(posedge clock);
    chk("drain", sb.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
